frame_parser: RTL and testbench
===============================

FRAME_PARSER -- requirements
Module: frame_parser

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of received words and of the checksum.
REQ-002 Parameter SYNC_WORD, default 8'hA5 (DATA_WIDTH bits), start-of-frame marker.
REQ-003 Parameter MAX_LEN, default 16, largest legal payload length in words.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, idle-cycle limit inside a frame.
REQ-005 clk_i  input  1  single clock; all logic on rising edge.
REQ-006 rst_n_i  input  1  reset, synchronous, active-low.
REQ-007 data_in_i  input  DATA_WIDTH  word from the upstream deserialized stream.
REQ-008 valid_in_i  input  1  data_in_i valid this cycle; no backpressure exists upstream.
REQ-009 payload_o  output  DATA_WIDTH  registered payload word.
REQ-010 payload_valid_o  output  1  payload_o valid, one cycle per word.
REQ-011 payload_last_o  output  1  marks final payload word of a frame.
REQ-012 frame_ok_o  output  1  one-cycle pulse, frame accepted.
REQ-013 frame_err_o  output  1  one-cycle pulse, frame rejected.
REQ-014 err_code_o  output  2  0 none, 1 length, 2 checksum, 3 timeout; valid while frame_err_o is high, else 0.
REQ-015 frame_count_o  output  16  good-frame count, wraps at 2^16.
REQ-016 err_count_o  output  16  rejected-frame count, saturates at 16'hFFFF.

Function
REQ-017 States HUNT, LEN, PAYLOAD, CHECK. Transitions occur only on a valid_in_i cycle, except timeout (REQ-025).
REQ-018 HUNT: a word equal to SYNC_WORD -> LEN. All other words are discarded.
REQ-019 LEN: the word is the length L. If L > MAX_LEN: frame_err_o, code 1, -> HUNT. If L = 0 -> CHECK. Otherwise -> PAYLOAD.
REQ-020 PAYLOAD: each word is emitted on payload_o with payload_valid_o on the next cycle (latency 1). After L words -> CHECK. SYNC_WORD values in PAYLOAD are treated as data.
REQ-021 The running sum is (L + all payload words) mod 2^DATA_WIDTH. It is cleared on entry to LEN.
REQ-022 CHECK: the word is compared with the running sum. On a match, frame_ok_o pulses and frame_count_o increments. On a mismatch, frame_err_o pulses with code 2. Both pulses fire one cycle after the check word arrives. -> HUNT.
REQ-023 Payload words are not retracted. Consumers qualify them with frame_ok_o or frame_err_o.
REQ-024 payload_last_o is asserted with the L-th payload word. It is never asserted when L = 0.
REQ-025 Gap counter: in LEN, PAYLOAD or CHECK, the counter counts consecutive cycles with valid_in_i low. It is cleared by any valid word. On reaching TIMEOUT_CYCLES: frame_err_o, code 3, -> HUNT.
REQ-026 Timeout and a valid word arriving in the same cycle: the valid word wins and the counter clears.
REQ-027 Every frame_err_o increments err_count_o, saturating.
REQ-028 frame_ok_o and frame_err_o are never asserted together.

Reset
REQ-029 When rst_n_i is low at a clock edge, the state goes to HUNT. The sum, gap counter, both counters and all outputs go to 0.
REQ-030 Reset mid-frame discards the frame silently: no error pulse and no count change.

Configuration
REQ-031 Macro FRAME_PARSER_CHECKSUM_EN, when defined, enables the CHECK state and the checksum error (code 2).
REQ-032 When the macro is undefined:
- PAYLOAD -> HUNT after the L-th word.
- frame_ok_o pulses in the same cycle as payload_last_o.
- When L = 0, frame_ok_o pulses one cycle after the length word.
- Code 2 is never produced.
- The sum logic is absent.

Structure
REQ-033 Package serdes_frame_pkg holds:
- the parser state enum;
- the err_code typedef;
- constants ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT.
REQ-034 The gap counter is the sub-module gap_timer. Its ports are clk_i, rst_n_i, enable_i, clear_i and expired_o.

Verification
REQ-035 Checksum enabled; stimulus A5, 03, 11, 22, 33, 69 -> payload 11, 22, 33 (last on 33), then frame_ok_o; frame_count_o = 1.
REQ-036 Stimulus A5, 02, 10, 20, 00 -> payload 10, 20, then frame_err_o with code 2; err_count_o = 1.
REQ-037 Stimulus A5, 11 with MAX_LEN = 16 -> frame_err_o with code 1; the next A5, 00, 00 gives frame_ok_o with no payload_valid_o.
REQ-038 Stimulus A5, 04, 01, then 64 idle cycles -> frame_err_o with code 3 exactly at the 64th idle cycle. A valid word on the 63rd idle cycle prevents the timeout.
REQ-039 Reset asserted between payload words -> no pulse, counters 0, and a following clean frame is accepted.
REQ-040 Macro undefined; stimulus A5, 02, A5, 7F -> payload A5, 7F with frame_ok_o on the 7F cycle.

Source files
------------

// File: rtl/serdes_frame_pkg.sv
// Shared types and constants for the serdes frame parser.
package serdes_frame_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } parser_state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_LEN     = 2'd1;
  localparam err_code_t ERR_CSUM    = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/gap_timer.sv
// Counts consecutive idle cycles while enabled; expired_o flags the cycle whose
// idle sample would be the TIMEOUT_CYCLES-th in a row. A clear always wins.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  assign expired_o = enable_i && !clear_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !enable_i || clear_i || expired_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/frame_parser.sv
// Frame parser: SYNC, LEN, payload and optional checksum word on a stream with no
// backpressure. Define FRAME_PARSER_CHECKSUM_EN to enable the CHECK word.
// Handshake: a word is consumed on every cycle valid_in_i is high (no ready);
// payload_valid_o qualifies payload_o for exactly one cycle per word.
module frame_parser
  import serdes_frame_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD      = 8'hA5,
  parameter int                    MAX_LEN        = 16,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  valid_in_i,
  output logic [DATA_WIDTH-1:0] payload_o,
  output logic                  payload_valid_o,
  output logic                  payload_last_o,
  output logic                  frame_ok_o,
  output logic                  frame_err_o,
  output logic [1:0]            err_code_o,
  output logic [15:0]           frame_count_o,
  output logic [15:0]           err_count_o,
  output logic [1:0]            state_o
);

  localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);

  parser_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] payload_d;
  logic                  pv_d, last_d, ok_d, err_d;
  err_code_t             code_d;
  logic                  expired;
`ifdef FRAME_PARSER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  assign state_o = state_q;

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .enable_i (state_q != ST_HUNT),
    .clear_i  (valid_in_i),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    payload_d = payload_o;
    pv_d      = 1'b0;
    last_d    = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = ERR_NONE;
`ifdef FRAME_PARSER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    if (valid_in_i) begin
      unique case (state_q)
        ST_HUNT: begin
          if (data_in_i == SYNC_WORD) begin
            state_d = ST_LEN;
`ifdef FRAME_PARSER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end
        end
        ST_LEN: begin
          len_d = data_in_i;
          cnt_d = '0;
`ifdef FRAME_PARSER_CHECKSUM_EN
          sum_d = data_in_i;
`endif
          if (data_in_i > MAX_LEN_W) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_HUNT;
          end else if (data_in_i == '0) begin
`ifdef FRAME_PARSER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            ok_d    = 1'b1;
            state_d = ST_HUNT;
`endif
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          // SYNC_WORD is plain data here; only the length ends the payload.
          payload_d = data_in_i;
          pv_d      = 1'b1;
          cnt_d     = cnt_q + 1'b1;
`ifdef FRAME_PARSER_CHECKSUM_EN
          sum_d     = sum_q + data_in_i;
`endif
          if (cnt_q + 1'b1 == len_q) begin
            last_d  = 1'b1;
`ifdef FRAME_PARSER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            ok_d    = 1'b1;
            state_d = ST_HUNT;
`endif
          end
        end
        ST_CHECK: begin
`ifdef FRAME_PARSER_CHECKSUM_EN
          if (data_in_i == sum_q) begin
            ok_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end
`endif
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (expired) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = ST_HUNT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q         <= ST_HUNT;
      len_q           <= '0;
      cnt_q           <= '0;
      payload_o       <= '0;
      payload_valid_o <= 1'b0;
      payload_last_o  <= 1'b0;
      frame_ok_o      <= 1'b0;
      frame_err_o     <= 1'b0;
      err_code_o      <= ERR_NONE;
      frame_count_o   <= '0;
      err_count_o     <= '0;
`ifdef FRAME_PARSER_CHECKSUM_EN
      sum_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      payload_o       <= payload_d;
      payload_valid_o <= pv_d;
      payload_last_o  <= last_d;
      frame_ok_o      <= ok_d;
      frame_err_o     <= err_d;
      err_code_o      <= code_d;
`ifdef FRAME_PARSER_CHECKSUM_EN
      sum_q           <= sum_d;
`endif
      if (ok_d) begin
        frame_count_o <= frame_count_o + 16'd1;
      end
      if (err_d && (err_count_o != 16'hFFFF)) begin
        err_count_o <= err_count_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_parser.sv
// Self-checking bench for frame_parser: directed frames plus random frames
// scored against a frame-level model (payload queue and frame-result queue).
module tb_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        vin = 1'b0;
  logic [7:0]  payload;
  logic        payload_valid, payload_last, frame_ok, frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_count, err_count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  // Scoreboard: {last, data} per payload word; frame results 4 = ok, 1..3 = error code.
  logic [8:0]  exp_q[$];
  logic [2:0]  ev_q[$];
  logic [15:0] m_good = 16'd0;
  logic [15:0] m_err = 16'd0;
  bit          csum_en;

  frame_parser dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .data_in_i      (din),
    .valid_in_i     (vin),
    .payload_o      (payload),
    .payload_valid_o(payload_valid),
    .payload_last_o (payload_last),
    .frame_ok_o     (frame_ok),
    .frame_err_o    (frame_err),
    .err_code_o     (err_code),
    .frame_count_o  (frame_count),
    .err_count_o    (err_count),
    .state_o        (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the stream; returns just after the edge that sampled the word.
  task automatic word(input logic v, input logic [7:0] d);
    @(negedge clk);
    vin = v;
    din = d;
    @(posedge clk);
    #1;
    vin = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bump_err();
    if (m_err != 16'hFFFF) m_err++;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_count"}, frame_count, m_good);
    chk({tag, "_err_count"}, err_count, m_err);
  endtask

  // kind: 0 good, 1 bad checksum (good when checksum is disabled), 2 length error
  task automatic send_frame(input int kind, input int max_gap);
    logic [7:0] len, sum, w;
    if (kind == 2) len = 8'($urandom_range(MAX_LEN + 1, 255));
    else           len = 8'($urandom_range(0, MAX_LEN));
    idle($urandom_range(0, max_gap));
    word(1'b1, SYNC);
    idle($urandom_range(0, max_gap));
    if (kind == 2) begin
      ev_q.push_back(3'd1);
      bump_err();
      word(1'b1, len);
      return;
    end
    word(1'b1, len);
    sum = len;
    for (int i = 0; i < int'(len); i++) begin
      w = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
      sum = sum + w;
      exp_q.push_back({(i == int'(len) - 1), w});
      idle($urandom_range(0, max_gap));
      word(1'b1, w);
    end
    if (csum_en) begin
      if (kind == 1) begin
        ev_q.push_back(3'd2);
        bump_err();
        w = sum + 8'($urandom_range(1, 255));
      end else begin
        ev_q.push_back(3'd4);
        m_good++;
        w = sum;
      end
      idle($urandom_range(0, max_gap));
      word(1'b1, w);
    end else begin
      ev_q.push_back(3'd4);
      m_good++;
    end
  endtask

  // Monitor: order of payload words and frame results against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (payload_valid) begin
        if (exp_q.size() == 0) chk("payload_unexpected", {payload_last, payload}, 9'h1FF);
        else chk("payload_word", {payload_last, payload}, exp_q.pop_front());
      end else if (payload_last) begin
        chk("last_without_valid", payload_last, 1'b0);
      end
      if (frame_ok || frame_err) begin
        chk("ok_err_exclusive", {frame_ok, frame_err}, {frame_ok, 1'b0} | {1'b0, frame_err & ~frame_ok});
        if (ev_q.size() == 0) chk("result_unexpected", {frame_ok, err_code}, 3'h7);
        else chk("frame_result", frame_ok ? 3'd4 : {1'b0, err_code}, ev_q.pop_front());
      end else if (err_code != 2'd0) begin
        chk("err_code_idle", err_code, 2'd0);
      end
    end
  end

  initial begin
`ifdef FRAME_PARSER_CHECKSUM_EN
    csum_en = 1'b1;
`else
    csum_en = 1'b0;
`endif
    // Reset state
    idle(3);
    chk("rst_payload_valid", payload_valid, 1'b0);
    chk("rst_payload", payload, 8'h00);
    chk("rst_last", payload_last, 1'b0);
    chk("rst_ok", frame_ok, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_code", err_code, 2'd0);
    check_counts("rst");
    rst_n = 1'b1;
    idle(2);

    // Basic good frame
    if (csum_en) begin
      exp_q.push_back({1'b0, 8'h11});
      exp_q.push_back({1'b0, 8'h22});
      exp_q.push_back({1'b1, 8'h33});
      ev_q.push_back(3'd4);
      m_good++;
      word(1'b1, 8'hA5); word(1'b1, 8'h03); word(1'b1, 8'h11);
      chk("d1_pv_11", payload_valid, 1'b1);
      chk("d1_payload_11", payload, 8'h11);
      word(1'b1, 8'h22); word(1'b1, 8'h33);
      chk("d1_last_33", {payload_last, payload}, {1'b1, 8'h33});
      chk("d1_no_ok_yet", frame_ok, 1'b0);
      word(1'b1, 8'h69);
      chk("d1_ok", frame_ok, 1'b1);
      chk("d1_no_pv_on_check", payload_valid, 1'b0);
    end else begin
      exp_q.push_back({1'b0, 8'hA5});
      exp_q.push_back({1'b1, 8'h7F});
      ev_q.push_back(3'd4);
      m_good++;
      word(1'b1, 8'hA5); word(1'b1, 8'h02); word(1'b1, 8'hA5);
      chk("d1_payload_sync_as_data", {payload_valid, payload_last, payload}, {2'b10, 8'hA5});
      chk("d1_no_ok_yet", frame_ok, 1'b0);
      word(1'b1, 8'h7F);
      chk("d1_last_7f", {payload_valid, payload_last, payload}, {2'b11, 8'h7F});
      chk("d1_ok_with_last", frame_ok, 1'b1);
    end
    check_counts("d1");

    // Checksum mismatch
    if (csum_en) begin
      exp_q.push_back({1'b0, 8'h10});
      exp_q.push_back({1'b1, 8'h20});
      ev_q.push_back(3'd2);
      bump_err();
      word(1'b1, 8'hA5); word(1'b1, 8'h02); word(1'b1, 8'h10); word(1'b1, 8'h20);
      word(1'b1, 8'h00);
      chk("d2_err", {frame_ok, frame_err, err_code}, {2'b01, 2'd2});
      check_counts("d2");
    end

    // Length error, then an empty frame
    ev_q.push_back(3'd1);
    bump_err();
    word(1'b1, 8'hA5); word(1'b1, 8'h11);
    chk("d3_len_err", {frame_ok, frame_err, err_code}, {2'b01, 2'd1});
    check_counts("d3");
    ev_q.push_back(3'd4);
    m_good++;
    word(1'b1, 8'hA5); word(1'b1, 8'h00);
    if (csum_en) begin
      chk("d3_no_ok_before_check", frame_ok, 1'b0);
      word(1'b1, 8'h00);
    end
    chk("d3_empty_ok", {frame_ok, payload_valid, payload_last}, 3'b100);
    check_counts("d3b");

    // Timeout at exactly the 64th idle cycle
    exp_q.push_back({1'b0, 8'h01});
    word(1'b1, 8'hA5); word(1'b1, 8'h04); word(1'b1, 8'h01);
    ev_q.push_back(3'd3);
    bump_err();
    idle(63);
    chk("d4_no_err_at_63", frame_err, 1'b0);
    idle(1);
    chk("d4_timeout", {frame_ok, frame_err, err_code}, {2'b01, 2'd3});
    check_counts("d4");

    // A word on the 63rd idle cycle keeps the frame alive
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b1, 8'h04});
    word(1'b1, 8'hA5); word(1'b1, 8'h04); word(1'b1, 8'h01);
    idle(62);
    word(1'b1, 8'h02);
    chk("d5_no_err_on_word", frame_err, 1'b0);
    idle(2);
    chk("d5_no_err_after", frame_err, 1'b0);
    ev_q.push_back(3'd4);
    m_good++;
    word(1'b1, 8'h03); word(1'b1, 8'h04);
    if (csum_en) word(1'b1, 8'h0E);
    chk("d5_ok", frame_ok, 1'b1);
    check_counts("d5");

    // Reset between payload words discards the frame silently
    word(1'b1, 8'hA5); word(1'b1, 8'h03); word(1'b1, 8'hAA);
    rst_n = 1'b0;
    idle(1);
    chk("d6_rst_outputs", {payload_valid, payload_last, frame_ok, frame_err, err_code}, 6'd0);
    m_good = 16'd0;
    m_err = 16'd0;
    check_counts("d6_rst");
    rst_n = 1'b1;
    send_frame(0, 2);
    check_counts("d6_clean");

    // Random frames with noise words in between
    for (int f = 0; f < 40; f++) begin
      int r;
      r = $urandom_range(0, 9);
      for (int n = $urandom_range(0, 2); n > 0; n--) begin
        logic [7:0] nz;
        nz = 8'($urandom);
        if (nz == SYNC) nz = 8'h00;
        word(1'b1, nz);
      end
      send_frame((r == 0) ? 2 : (r == 1) ? 1 : 0, 4);
      check_counts("rand");
    end

    idle(4);
    chk("payload_queue_drained", exp_q.size(), 0);
    chk("result_queue_drained", ev_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
